// File: rtl/set_reset_debouncer.sv
// set_reset_debouncer: synchronizes and debounces raw set/reset inputs into levels,
// rising-edge pulses (reset wins on conflict) and a data/rw write pair for d_latch.
module debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic lvl,
    output logic rise
);
    typedef enum logic [1:0] {STABLE_LO, CNT_UP, STABLE_HI, CNT_DN} state_t;
    state_t state;
    logic [1:0] sync;
    logic [CNT_W-1:0] cnt;
    logic s, done;
    assign s = sync[1];
    assign done = cnt == CNT_W'(DEBOUNCE_CYCLES);
    // rise is the commit condition, so the top can register its pulse on the same edge as lvl
    assign rise = state == CNT_UP && s && done;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            state <= STABLE_LO;
            cnt   <= '0;
            lvl   <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            case (state)
                STABLE_LO: begin
                    state <= s ? CNT_UP : STABLE_LO;
                    cnt   <= s ? CNT_W'(1) : '0;
                end
                CNT_UP: begin
                    if (!s) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                    end else if (done) begin
                        state <= STABLE_HI;
                        lvl   <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STABLE_HI: begin
                    state <= !s ? CNT_DN : STABLE_HI;
                    cnt   <= !s ? CNT_W'(1) : '0;
                end
                CNT_DN: begin
                    if (s) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                    end else if (done) begin
                        state <= STABLE_LO;
                        lvl   <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end
endmodule

module set_reset_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_raw,
    input  logic reset_raw,
    output logic set_lvl,
    output logic reset_lvl,
    output logic set_pulse,
    output logic reset_pulse,
    output logic data,
    output logic rw
);
    logic set_rise, reset_rise;
    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_set (
        .clk(clk), .rst_n(rst_n), .raw(set_raw), .lvl(set_lvl), .rise(set_rise)
    );
    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_reset (
        .clk(clk), .rst_n(rst_n), .raw(reset_raw), .lvl(reset_lvl), .rise(reset_rise)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_pulse   <= 1'b0;
            reset_pulse <= 1'b0;
            rw          <= 1'b0;
            data        <= 1'b0;
        end else begin
            set_pulse   <= set_rise & ~reset_rise;
            reset_pulse <= reset_rise;
            rw          <= set_rise | reset_rise;
            if (set_rise | reset_rise) data <= ~reset_rise;
        end
    end
endmodule

// File: tb/tb_set_reset_debouncer.sv
// tb_set_reset_debouncer: scenario tasks with directed checks plus a run-length
// reference model feeding a scoreboard of expected output vectors.
module tb_set_reset_debouncer;
    localparam int D = 4;
    logic clk = 1'b0, rst_n = 1'b0, set_raw = 1'b0, reset_raw = 1'b0;
    logic set_lvl, reset_lvl, set_pulse, reset_pulse, data, rw;
    logic [5:0] obs;
    int checks = 0, errors = 0;
    logic [5:0] sb[$];
    logic [1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0;
    int m_run[2] = '{0, 0};
    logic m_data = 1'b0;

    set_reset_debouncer #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst_n(rst_n), .set_raw(set_raw), .reset_raw(reset_raw),
        .set_lvl(set_lvl), .reset_lvl(reset_lvl), .set_pulse(set_pulse),
        .reset_pulse(reset_pulse), .data(data), .rw(rw)
    );

    always #5 clk = ~clk;
    assign obs = {set_lvl, reset_lvl, set_pulse, reset_pulse, data, rw};

    // Level flips once the synchronized input has differed for D+1 consecutive edges
    always @(posedge clk or negedge rst_n) begin : model
        logic [1:0] rose;
        logic sp, rp;
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_run[0] = 0; m_run[1] = 0; m_data = 1'b0;
            sb.delete();
        end else begin
            rose = '0;
            for (int c = 0; c < 2; c++) begin
                m_run[c] = (m_s2[c] != m_lvl[c]) ? m_run[c] + 1 : 0;
                if (m_run[c] == D + 1) begin
                    m_lvl[c] = ~m_lvl[c];
                    m_run[c] = 0;
                    rose[c] = m_lvl[c];
                end
            end
            m_s2 = m_s1;
            m_s1 = {reset_raw, set_raw};
            rp = rose[1];
            sp = rose[0] & ~rp;
            if (sp | rp) m_data = sp;
            sb.push_back({m_lvl[0], m_lvl[1], sp, rp, m_data, sp | rp});
        end
    end

    task automatic do_reset();
        rst_n = 1'b0; set_raw = 1'b0; reset_raw = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [5:0] exp;
        rst_n = 1'b0; set_raw = 1'b1; reset_raw = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (obs !== 6'b0) begin errors++; $display("FAIL reset_hold got %b exp 000000", obs); end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL reset_sb empty cyc %0d", i); end
            else begin
                exp = sb.pop_front();
                if (obs !== exp) begin errors++; $display("FAIL reset_sb cyc %0d got %b exp %b", i, obs, exp); end
            end
            checks++;
            if (set_lvl !== (i >= 6)) begin errors++; $display("FAIL reset_set_lvl cyc %0d got %b exp %b", i, set_lvl, i >= 6); end
            if (i < 6) begin
                checks++;
                if (obs !== 6'b0) begin errors++; $display("FAIL reset_zero cyc %0d got %b exp 000000", i, obs); end
            end
        end
    endtask

    task automatic test_clean_set();
        logic [5:0] exp;
        do_reset();
        set_raw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL clean_sb empty cyc %0d", i); end
            else begin
                exp = sb.pop_front();
                if (obs !== exp) begin errors++; $display("FAIL clean_sb cyc %0d got %b exp %b", i, obs, exp); end
            end
            if (i == 5 || i == 6 || i == 7) begin
                exp = i == 5 ? 6'b000000 : i == 6 ? 6'b101011 : 6'b100010;
                checks++;
                if (obs !== exp) begin errors++; $display("FAIL clean_edge cyc %0d got %b exp %b", i, obs, exp); end
            end
        end
    endtask

    task automatic test_bounce();
        logic [5:0] exp;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            set_raw = (i < 3) || (i >= 4 && i < 7);
            @(negedge clk);
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL bounce_sb empty cyc %0d", i); end
            else begin
                exp = sb.pop_front();
                if (obs !== exp) begin errors++; $display("FAIL bounce_sb cyc %0d got %b exp %b", i, obs, exp); end
            end
            checks++;
            if ({set_lvl, set_pulse, rw} !== 3'b0) begin
                errors++; $display("FAIL bounce_quiet cyc %0d got %b exp 000", i, {set_lvl, set_pulse, rw});
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [5:0] exp;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            set_raw = i < 10 || i >= 22;
            reset_raw = i >= 22;
            @(negedge clk);
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL simul_sb empty cyc %0d", i); end
            else begin
                exp = sb.pop_front();
                if (obs !== exp) begin errors++; $display("FAIL simul_sb cyc %0d got %b exp %b", i, obs, exp); end
            end
            if (i == 27 || i == 28 || i == 29) begin
                exp = i == 27 ? 6'b000010 : i == 28 ? 6'b110101 : 6'b110000;
                checks++;
                if (obs !== exp) begin errors++; $display("FAIL simul_edge cyc %0d got %b exp %b", i, obs, exp); end
            end
        end
    endtask

    task automatic test_release();
        logic [5:0] exp;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_raw = i < 8;
            @(negedge clk);
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL release_sb empty cyc %0d", i); end
            else begin
                exp = sb.pop_front();
                if (obs !== exp) begin errors++; $display("FAIL release_sb cyc %0d got %b exp %b", i, obs, exp); end
            end
            if (i >= 8) begin
                exp = i < 14 ? 6'b100010 : 6'b000010;
                checks++;
                if (obs !== exp) begin errors++; $display("FAIL release_fall cyc %0d got %b exp %b", i, obs, exp); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] exp;
        do_reset();
        set_raw = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL mid_sb empty cyc %0d", i); end
            else begin
                exp = sb.pop_front();
                if (obs !== exp) begin errors++; $display("FAIL mid_sb cyc %0d got %b exp %b", i, obs, exp); end
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 6'b0) begin errors++; $display("FAIL mid_reset got %b exp 000000", obs); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL mid_post_sb empty cyc %0d", i); end
            else begin
                exp = sb.pop_front();
                if (obs !== exp) begin errors++; $display("FAIL mid_post_sb cyc %0d got %b exp %b", i, obs, exp); end
            end
            checks++;
            if ({set_lvl, set_pulse} !== {i >= 6, i == 6}) begin
                errors++; $display("FAIL mid_pulse cyc %0d got %b exp %b", i, {set_lvl, set_pulse}, {i >= 6, i == 6});
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] exp;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) set_raw = ~set_raw;
            if ($urandom_range(0, 6) == 0) reset_raw = ~reset_raw;
            @(negedge clk);
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL random_sb empty cyc %0d", i); end
            else begin
                exp = sb.pop_front();
                if (obs !== exp) begin errors++; $display("FAIL random_sb cyc %0d got %b exp %b", i, obs, exp); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_set();
        test_bounce();
        test_simultaneous();
        test_release();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/set_reset_debouncer.md
# set_reset_debouncer

Conditions two raw, asynchronous, bouncy inputs (set and reset buttons or off-block strobes) into clean, clock-aligned control for the latch stage. It synchronizes and debounces each input, then emits stable levels, single-cycle edge pulses, and a data/rw write pair. The set/reset outputs drive `and_or_latch` directly; the data/rw outputs drive `d_latch`. It sits directly upstream of both latches.

## Interface

- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized cycles an input must differ from its stable level before the level flips. Legal range is 1 or more.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: counter width, derived. It must not be overridden smaller.

Ports:

- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst_n`, input, 1: reset. Asynchronous, active-low.
- `set_raw`, input, 1: raw set request. Asynchronous to `clk` and may bounce.
- `reset_raw`, input, 1: raw reset request. Asynchronous to `clk` and may bounce.
- `set_lvl`, output, 1: debounced set level. Registered.
- `reset_lvl`, output, 1: debounced reset level. Registered.
- `set_pulse`, output, 1: one-cycle pulse on the rising edge of `set_lvl`. Registered.
- `reset_pulse`, output, 1: one-cycle pulse on the rising edge of `reset_lvl`. Registered.
- `data`, output, 1: value to write into `d_latch`. Registered.
- `rw`, output, 1: one-cycle write strobe for `d_latch`. Registered.

## Operation

- Each channel has a 2-flop synchronizer, giving sync signal `s`. This is followed by a debounce FSM and a counter `cnt`.
- The FSM has four states per channel:
  - STABLE_LO: `lvl`=0. If `s`=1, go to CNT_UP with `cnt`=1. Otherwise stay, with `cnt`=0.
  - CNT_UP: if `s`=0, return to STABLE_LO with `cnt`=0. If `s`=1 and `cnt`==`DEBOUNCE_CYCLES`, go to STABLE_HI, set `lvl`=1 and `cnt`=0. Otherwise `cnt`+1.
  - STABLE_HI and CNT_DN: mirror images of the above, with `s`=0 counting toward `lvl`=0.
  - With `DEBOUNCE_CYCLES`=1, the first differing cycle enters CNT and the next matching cycle commits.
- Net effect: `lvl` flips only after `s` differs from `lvl` for exactly `DEBOUNCE_CYCLES`+1 consecutive edges, counting the entry edge. A shorter excursion leaves `lvl` unchanged and clears `cnt`.
- Counters never exceed `DEBOUNCE_CYCLES` and never wrap.
- Pulse generation: `x_pulse`=1 for exactly the cycle in which `x_lvl` first reads 1. Falling edges of `lvl` produce no pulse.
- Conflict rule, reset wins: if `set_pulse` and `reset_pulse` would assert in the same cycle, only `reset_pulse` asserts. The set pulse is dropped, not deferred. `set_lvl` still updates normally.
- d_latch drive:
  - `rw`=1 for one cycle coincident with any emitted pulse.
  - `data`=1 when the emitted pulse is `set_pulse` and 0 when it is `reset_pulse`.
  - `data` holds its last value while `rw`=0.
- Reset (`rst_n`=0, asynchronous) clears everything immediately, including mid-count:
  - Synchronizers, counters and outputs all go to 0.
  - Both FSMs go to STABLE_LO.
  - After release, any input already high must complete a full debounce and then emits a pulse.

## Timing

- Latency: `set_raw` rises and is captured by sync stage 1 at edge k. `s` rises at edge k+1. `set_lvl`, `set_pulse`, `rw` and `data` all update at edge k+2+`DEBOUNCE_CYCLES`. The falling path has the same latency and produces only a `lvl` change.
- Pulse width is exactly 1 cycle. Steady state produces no back-to-back pulses on a channel.
- The minimum spacing between two pulses on one channel is 2×(`DEBOUNCE_CYCLES`+1) cycles.
- All outputs come straight from flops. No combinational path runs from raw inputs to outputs.
- Reset values: `set_lvl`, `reset_lvl`, `set_pulse`, `reset_pulse`, `data` and `rw` are all 0.

## Test plan

- **Reset values:** assert `rst_n`=0 with both raw inputs at 1. All six outputs must read 0 during reset and stay 0 for 5 cycles after release. `set_lvl` must rise at cycle 6, with `DEBOUNCE_CYCLES`=4.
- **Clean set:** hold `set_raw`=1 from edge 0, with `DEBOUNCE_CYCLES`=4. At edge 6, `set_lvl`=1, `set_pulse`=1, `rw`=1 and `data`=1. At edge 7, `set_pulse`=0 and `rw`=0 while `data` stays 1.
- **Bounce:** drive `set_raw` high for 3 cycles, low for 1, high for 3, then low. `set_lvl`, `set_pulse` and `rw` must stay 0 throughout.
- **Simultaneous press:** raise `set_raw` and `reset_raw` on the same edge. At edge 6, `reset_pulse`=1, `set_pulse`=0, `data`=0, `rw`=1, and both levels are 1.
- **Release:** after a set, drop `set_raw`. `set_lvl` falls 6 cycles later, and no pulse or `rw` occurs.
- **Reset mid-count:** assert `rst_n`=0 for 1 cycle at edge 4 of a set press. All outputs return to 0. After release, `set_pulse` occurs exactly 6 edges after the first post-reset edge.
